// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared funct3 codes, dmem lane modes, FSM state encoding and
//               access-size helpers for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // dmem lane modes (low two bits of dmem_*_mode)
  localparam logic [1:0] MODE_BYTE = 2'd0;
  localparam logic [1:0] MODE_WORD = 2'd2;

  // Unit sequencing states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_LO = 3'd1,
    ISSUE_HI = 3'd2,
    CAPTURE  = 3'd3,
    DONE     = 3'd4
  } lsu_state_t;

  // Byte-sized access (signed or unsigned)
  function automatic logic f3_is_byte(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LBU);
  endfunction

  // Halfword access (signed or unsigned), split into two byte accesses
  function automatic logic f3_is_half(input logic [2:0] f3);
    return (f3 == F3_LH) || (f3 == F3_LHU);
  endfunction

  // Everything else, including the unassigned encodings, is a word access
  function automatic logic f3_is_word(input logic [2:0] f3);
    return !(f3_is_byte(f3) || f3_is_half(f3));
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_format.sv
// ============================================================================
// Module      : lsu_load_format
// Description : Combinational assembly of load byte lanes and sign/zero
//               extension. For halfwords the low byte comes from an earlier
//               byte access and the high byte from the current read data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_format
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rdata,
  input  logic [7:0]  i_lo_byte,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unsigned;

  // Memory returns a zero-extended lane in [7:0] for byte reads
  assign w_byte     = i_rdata[7:0];
  assign w_half     = {i_rdata[7:0], i_lo_byte};
  assign w_unsigned = i_funct3[2];

  // Pick the lane width from funct3 and extend according to funct3[2]
  always_comb begin
    o_data = i_rdata;
    if (f3_is_byte(i_funct3)) begin
      o_data = w_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
    end else if (f3_is_half(i_funct3)) begin
      o_data = w_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
    end
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : CPU-side data-memory initiator. Takes one load/store request
//               at a time, drives the dmem bus (byte and word lanes only, so
//               halfwords become two byte accesses), honours dmem_wait and the
//               one-cycle registered read latency, extends load results and
//               rejects misaligned word accesses without touching memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_write_data,
  output logic                  resp_valid,
  output logic [31:0]           resp_read_data,
  output logic                  resp_misaligned,
  output logic [ADDR_WIDTH-1:0] dmem_address,
  output logic                  dmem_enable,
  output logic [31:0]           dmem_write_data,
  output logic                  dmem_write_enable,
  output logic [2:0]            dmem_write_mode,
  output logic                  dmem_read_enable,
  output logic [2:0]            dmem_read_mode,
  input  logic [31:0]           dmem_read_data,
  input  logic                  dmem_wait
);

  lsu_state_t            r_state;
  lsu_state_t            w_state_next;

  logic                  r_write;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [ADDR_WIDTH-1:0] r_dmem_addr;
  logic [7:0]            r_lo_byte;
  logic                  r_lo_done;
  logic [31:0]           r_result;
  logic                  r_misaligned;

  logic                  w_ready;
  logic                  w_issue;
  logic [31:0]           w_lane_data;
  logic [1:0]            w_mode;
  logic                  w_word;
  logic                  w_half;
  logic                  w_req_misaligned;
  logic [31:0]           w_load_result;

  assign w_word = f3_is_word(r_funct3);
  assign w_half = f3_is_half(r_funct3);

  // Word accesses must be naturally aligned; anything else is answered at once
  assign w_req_misaligned = f3_is_word(req_funct3) && (req_address[1:0] != 2'b00);

  // Ready is forced low while reset is held so nothing is accepted in reset
  assign req_ready       = w_ready & reset_n;
  assign resp_read_data  = r_result;
  assign resp_misaligned = r_misaligned;
  assign dmem_address    = r_dmem_addr;

  lsu_load_format u_load_format (
    .i_funct3  (r_funct3),
    .i_rdata   (dmem_read_data),
    .i_lo_byte (r_lo_byte),
    .o_data    (w_load_result)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and dmem/response strobes
  always_comb begin
    w_state_next      = r_state;
    w_ready           = 1'b0;
    resp_valid        = 1'b0;
    w_issue           = 1'b0;
    w_lane_data       = 32'h0;
    w_mode            = MODE_BYTE;
    dmem_enable       = 1'b0;
    dmem_write_enable = 1'b0;
    dmem_read_enable  = 1'b0;
    dmem_write_data   = 32'h0;
    dmem_write_mode   = 3'b000;
    dmem_read_mode    = 3'b000;

    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (req_valid) begin
          w_state_next = w_req_misaligned ? DONE : ISSUE_LO;
        end
      end

      ISSUE_LO: begin
        w_issue = 1'b1;
        if (w_word) begin
          w_mode      = MODE_WORD;
          w_lane_data = r_wdata;
        end else begin
          w_lane_data = {24'h0, r_wdata[7:0]};
        end
        if (!dmem_wait) begin
          w_state_next = w_half ? ISSUE_HI : CAPTURE;
        end
      end

      ISSUE_HI: begin
        w_issue     = 1'b1;
        w_lane_data = {24'h0, r_wdata[15:8]};
        if (!dmem_wait) begin
          w_state_next = CAPTURE;
        end
      end

      CAPTURE: begin
        w_state_next = DONE;
      end

      DONE: begin
        resp_valid   = 1'b1;
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Only the active strobe's mode/data are non-zero; read mode always asks
    // the memory for a zero-extended lane
    if (w_issue) begin
      dmem_enable       = 1'b1;
      dmem_write_enable = r_write;
      dmem_read_enable  = !r_write;
      if (r_write) begin
        dmem_write_data = w_lane_data;
        dmem_write_mode = {1'b0, w_mode};
      end else begin
        dmem_read_mode  = {1'b1, w_mode};
      end
    end
  end

  // Request latch, bus address, low-byte capture and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_write      <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr       <= '0;
      r_wdata      <= 32'h0;
      r_dmem_addr  <= '0;
      r_lo_byte    <= 8'h0;
      r_lo_done    <= 1'b0;
      r_result     <= 32'h0;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write      <= req_write;
            r_funct3     <= req_funct3;
            r_addr       <= req_address;
            r_wdata      <= req_write_data;
            r_misaligned <= w_req_misaligned;
            r_result     <= 32'h0;
            r_lo_done    <= 1'b0;
            // A rejected access leaves the bus address untouched
            if (!w_req_misaligned) begin
              r_dmem_addr <= req_address;
            end
          end
        end

        ISSUE_LO: begin
          // Second byte of a halfword may carry into the next word
          if (!dmem_wait && w_half) begin
            r_dmem_addr <= r_addr + ADDR_WIDTH'(1);
          end
        end

        ISSUE_HI: begin
          // Read data from the low-byte issue is only valid on the first
          // ISSUE_HI cycle; later stall cycles must not overwrite it
          if (!r_lo_done) begin
            r_lo_byte <= dmem_read_data[7:0];
            r_lo_done <= 1'b1;
          end
        end

        CAPTURE: begin
          r_result <= r_write ? 32'h0 : w_load_result;
        end

        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. A byte-array memory
//               answers the dmem bus; a transaction-level model predicts each
//               request's bus accesses, response data, flag and timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic        resp_valid;
  logic [31:0] resp_read_data;
  logic        resp_misaligned;
  logic [31:0] dmem_address;
  logic        dmem_enable;
  logic [31:0] dmem_write_data;
  logic        dmem_write_enable;
  logic [2:0]  dmem_write_mode;
  logic        dmem_read_enable;
  logic [2:0]  dmem_read_mode;
  logic [31:0] dmem_read_data;
  logic        dmem_wait;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_funct3        (req_funct3),
    .req_address       (req_address),
    .req_write_data    (req_write_data),
    .resp_valid        (resp_valid),
    .resp_read_data    (resp_read_data),
    .resp_misaligned   (resp_misaligned),
    .dmem_address      (dmem_address),
    .dmem_enable       (dmem_enable),
    .dmem_write_data   (dmem_write_data),
    .dmem_write_enable (dmem_write_enable),
    .dmem_write_mode   (dmem_write_mode),
    .dmem_read_enable  (dmem_read_enable),
    .dmem_read_mode    (dmem_read_mode),
    .dmem_read_data    (dmem_read_data),
    .dmem_wait         (dmem_wait)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- memory + transaction model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [2:0]  wmode;
    logic [2:0]  rmode;
    logic [31:0] wdata;
  } acc_t;

  logic [7:0]  mem [0:255];
  logic        mem_ready = 1'b0;
  acc_t        exp_q[$];
  logic        busy = 1'b0;
  logic [31:0] exp_data;
  logic        exp_mis;
  int          exp_lat, acc_cyc, stalls, en_cycles;
  int          pend_cyc = -1;
  logic [31:0] pend_data;
  logic [2:0]  last_rmode;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [7:0] rd(input logic [31:0] a, input int k);
    logic [7:0] ix;
    ix = a[7:0] + 8'(k);
    return mem[ix];
  endfunction

  // What a load must return, straight from memory contents
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] b0, b1;
    b0 = rd(a, 0);
    b1 = rd(a, 1);
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b100:  return {24'h0, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return {rd(a, 3), rd(a, 2), b1, b0};
    endcase
  endfunction

  // Memory read port: data for an access issued in cycle N appears in N+1
  always @(posedge clk) begin
    #1;
    dmem_read_data = (pend_cyc == cyc) ? pend_data : $urandom;
  end

  // Compare process: checks the bus and response every cycle
  always @(negedge clk) begin : p_cmp
    acc_t       e;
    int         sz;
    logic [1:0] md;
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 1);
      mem[8'h03] = 8'h80;
      mem[8'h10] = 8'hEF; mem[8'h11] = 8'hBE; mem[8'h12] = 8'hAD; mem[8'h13] = 8'hDE;
      mem_ready = 1'b1;
    end
    if (!reset_n) begin
      busy     = 1'b0;
      pend_cyc = -1;
      exp_q.delete();
    end else begin
      chk("req_ready", req_ready, !busy);
      if (dmem_enable) begin
        en_cycles++;
        last_rmode = dmem_read_mode;
        if (exp_q.size() == 0) begin
          chk("dmem_unexpected", 1, 0);
        end else begin
          e = exp_q[0];
          chk("dmem_addr", dmem_address, e.addr);
          chk("dmem_ctrl", {dmem_write_enable, dmem_read_enable, dmem_write_mode, dmem_read_mode},
              {e.we, !e.we, e.wmode, e.rmode});
          chk("dmem_wdata", dmem_write_data, e.wdata);
          if (dmem_wait) begin
            stalls++;
          end else begin
            void'(exp_q.pop_front());
            log_addr.push_back(dmem_address);
            log_data.push_back(dmem_write_data);
            if (e.we) begin
              if (e.wmode[1:0] == 2'd2) begin
                for (int k = 0; k < 4; k++) mem[e.addr[7:0] + 8'(k)] = e.wdata[8*k +: 8];
              end else begin
                mem[e.addr[7:0]] = e.wdata[7:0];
              end
            end else begin
              pend_cyc  = cyc + 1;
              pend_data = (e.rmode[1:0] == 2'd2) ?
                          {rd(e.addr, 3), rd(e.addr, 2), rd(e.addr, 1), rd(e.addr, 0)} :
                          {24'h0, rd(e.addr, 0)};
            end
          end
        end
      end else begin
        chk("dmem_idle", {dmem_write_enable, dmem_read_enable, dmem_write_mode, dmem_read_mode, dmem_write_data}, 0);
      end
      if (resp_valid) begin
        if (!busy) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          chk("resp_data", resp_read_data, exp_data);
          chk("resp_misaligned", resp_misaligned, exp_mis);
          chk("resp_cycle", cyc, acc_cyc + exp_lat + stalls);
          chk("accesses_left", exp_q.size(), 0);
          busy = 1'b0;
        end
      end
      if (req_valid && req_ready) begin
        sz = size_of(req_funct3);
        exp_q.delete();
        log_addr.delete();
        log_data.delete();
        stalls    = 0;
        en_cycles = 0;
        acc_cyc   = cyc;
        busy      = 1'b1;
        if (sz == 4 && req_address[1:0] != 2'b00) begin
          exp_mis  = 1'b1;
          exp_data = 32'h0;
          exp_lat  = 1;
        end else begin
          exp_mis  = 1'b0;
          exp_data = req_write ? 32'h0 : model_load(req_funct3, req_address);
          exp_lat  = (sz == 2) ? 4 : 3;
          md       = (sz == 4) ? 2'd2 : 2'd0;
          for (int k = 0; k < ((sz == 2) ? 2 : 1); k++) begin
            e.addr  = req_address + 32'(k);
            e.we    = req_write;
            e.wmode = req_write ? {1'b0, md} : 3'b000;
            e.rmode = req_write ? 3'b000 : {1'b1, md};
            e.wdata = !req_write ? 32'h0 :
                      (sz == 4) ? req_write_data : {24'h0, req_write_data[8*k +: 8]};
            exp_q.push_back(e);
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_req(input string nm, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input int wlo, input int whi,
                        input logic [31:0] xd, input logic xm, input int xl);
    int t0;
    bit seen;
    @(posedge clk); #1;
    req_valid      = 1'b1;
    req_write      = w;
    req_funct3     = f3;
    req_address    = a;
    req_write_data = d;
    t0             = cyc;
    @(posedge clk); #1;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_write_data = 32'h0;
    dmem_wait      = (wlo > 0);
    repeat (wlo) begin @(posedge clk); #1; end
    dmem_wait = 1'b0;
    if (whi > 0) begin
      @(posedge clk); #1;
      dmem_wait = 1'b1;
      repeat (whi) begin @(posedge clk); #1; end
      dmem_wait = 1'b0;
    end
    seen = 0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1;
        chk({nm, "_data"}, resp_read_data, xd);
        chk({nm, "_mis"}, resp_misaligned, xm);
        chk({nm, "_latency"}, cyc - t0, xl);
      end
    end
    if (!seen) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    reset_n        = 1'b0;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_funct3     = 3'b000;
    req_address    = 32'h0;
    req_write_data = 32'h0;
    dmem_wait      = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("ready_in_reset", req_ready, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_ctrl", {resp_valid, resp_misaligned, dmem_enable, dmem_write_enable, dmem_read_enable,
                     dmem_write_mode, dmem_read_mode}, 0);
    chk("rst_addr_rdata", {dmem_address, resp_read_data}, 0);
    chk("rst_wdata", dmem_write_data, 0);

    // Word load
    do_req("lw", 1'b0, 3'b010, 32'h8000_0010, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 3);
    chk("lw_en_cycles", en_cycles, 1);
    chk("lw_read_mode", last_rmode, 3'b110);

    // Byte loads, signed and unsigned
    do_req("lb", 1'b0, 3'b000, 32'h8000_0003, 32'h0, 0, 0, 32'hFFFF_FF80, 1'b0, 3);
    do_req("lbu", 1'b0, 3'b100, 32'h8000_0003, 32'h0, 0, 0, 32'h0000_0080, 1'b0, 3);

    // Halfword store split into two byte writes across a word boundary
    do_req("sh", 1'b1, 3'b001, 32'h8000_0003, 32'h0000_A55A, 0, 0, 32'h0, 1'b0, 4);
    chk("sh_accesses", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("sh_lo", {log_addr[0], log_data[0]}, {32'h8000_0003, 32'h0000_005A});
      chk("sh_hi", {log_addr[1], log_data[1]}, {32'h8000_0004, 32'h0000_00A5});
    end
    do_req("lh", 1'b0, 3'b001, 32'h8000_0003, 32'h0, 0, 0, 32'hFFFF_A55A, 1'b0, 4);
    do_req("lhu", 1'b0, 3'b101, 32'h8000_0003, 32'h0, 0, 0, 32'h0000_A55A, 1'b0, 4);

    // Misaligned word store: no bus activity
    do_req("sw_mis", 1'b1, 3'b010, 32'h8000_0002, 32'h1111_2222, 0, 0, 32'h0, 1'b1, 1);
    chk("sw_mis_en_cycles", en_cycles, 0);
    do_req("lw_mis", 1'b0, 3'b010, 32'h8000_0001, 32'h0, 0, 0, 32'h0, 1'b1, 1);

    // Stall in ISSUE_LO for three cycles
    do_req("lw_wait", 1'b0, 3'b010, 32'h8000_0010, 32'h0, 3, 0, 32'hDEAD_BEEF, 1'b0, 6);
    chk("lw_wait_en_cycles", en_cycles, 4);

    // Word store then partial reads of it
    do_req("sw", 1'b1, 3'b010, 32'h8000_0020, 32'h1234_5678, 0, 0, 32'h0, 1'b0, 3);
    do_req("lw_back", 1'b0, 3'b010, 32'h8000_0020, 32'h0, 0, 0, 32'h1234_5678, 1'b0, 3);
    do_req("lb_21", 1'b0, 3'b000, 32'h8000_0021, 32'h0, 0, 0, 32'h0000_0056, 1'b0, 3);
    do_req("lb_23", 1'b0, 3'b000, 32'h8000_0023, 32'h0, 0, 0, 32'h0000_0012, 1'b0, 3);
    // Halfword load with a stall during the high byte
    do_req("lh_wait", 1'b0, 3'b001, 32'h8000_0022, 32'h0, 0, 2, 32'h0000_1234, 1'b0, 6);

    // Byte store, then read back both ways
    do_req("sb", 1'b1, 3'b000, 32'h8000_0025, 32'hFFFF_FF99, 0, 0, 32'h0, 1'b0, 3);
    do_req("lbu_25", 1'b0, 3'b100, 32'h8000_0025, 32'h0, 0, 0, 32'h0000_0099, 1'b0, 3);
    do_req("lb_25", 1'b0, 3'b000, 32'h8000_0025, 32'h0, 0, 0, 32'hFFFF_FF99, 1'b0, 3);

    // Halfword crossing a word boundary from preloaded memory
    do_req("lhu_07", 1'b0, 3'b101, 32'h8000_0007, 32'h0, 0, 0, 32'h0000_3932, 1'b0, 4);

    // Unassigned funct3 codes behave as word accesses
    do_req("f3_011", 1'b0, 3'b011, 32'h8000_0010, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 3);
    do_req("f3_110", 1'b0, 3'b110, 32'h8000_0010, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 3);
    do_req("f3_111_mis", 1'b1, 3'b111, 32'h8000_0011, 32'h0, 0, 0, 32'h0, 1'b1, 1);

    // Reset asserted during ISSUE_HI of a halfword load
    @(posedge clk); #1;
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_funct3  = 3'b001;
    req_address = 32'h8000_0003;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #3;
    chk("pre_reset_issuing", dmem_enable, 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {req_ready, resp_valid, resp_misaligned, dmem_enable, dmem_write_enable,
                           dmem_read_enable, dmem_write_mode, dmem_read_mode}, 0);
    chk("async_rst_addr_rdata", {dmem_address, resp_read_data}, 0);
    chk("async_rst_wdata", dmem_write_data, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", {req_ready, resp_valid}, 2'b10);
    end
    do_req("lw_after_rst", 1'b0, 3'b010, 32'h8000_0010, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 3);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal;
  end

endmodule

`default_nettype wire
